// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcodes, FSM encoding and op classification shared by seq_alu files
package seq_alu_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_SHR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_POW = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Divide by zero is resolved in one cycle, so it never enters the engine.
   function automatic logic is_iter_op(input logic [2:0] op, input logic div_by_zero);
      return (op == OP_MUL) || (op == OP_POW) || ((op == OP_DIV) && !div_by_zero);
   endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - iterative engine: shift-add MUL, restoring DIV, repeated-multiply POW
module seq_alu_iter
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o,
   output logic             ovf_o
);

   // POW runs up to 2**WIDTH-1 steps, so the counter must also hold a full operand.
   localparam int IT_W = (CNT_W > WIDTH) ? CNT_W : WIDTH;

   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             ovf_q, ovf_d;
   logic             skip_q, skip_d;
   logic             busy_q, busy_d;
   logic [IT_W-1:0]  cnt_q, cnt_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic               div_ge;
   logic [2*WIDTH-1:0] pow_prod;
   logic [WIDTH-1:0]   x_step;
   logic [WIDTH-1:0]   y_step;
   logic               ovf_step;

   // x: MUL high half / DIV remainder / POW accumulator; y: MUL low half / DIV quotient; z: multiplicand, divisor or base
   always_comb begin
      mul_sum  = {1'b0, x_q} + (y_q[0] ? {1'b0, z_q} : {(WIDTH+1){1'b0}});
      div_sh   = {x_q, y_q[WIDTH-1]};
      div_ge   = (div_sh >= {1'b0, z_q});
      pow_prod = {{WIDTH{1'b0}}, x_q} * {{WIDTH{1'b0}}, z_q};
      x_step   = x_q;
      y_step   = y_q;
      ovf_step = ovf_q;
      case (op_q)
         OP_MUL: begin
            x_step   = mul_sum[WIDTH:1];
            y_step   = {mul_sum[0], y_q[WIDTH-1:1]};
            ovf_step = |mul_sum[WIDTH:1];
         end
         OP_DIV: begin
            x_step   = div_ge ? (div_sh[WIDTH-1:0] - z_q) : div_sh[WIDTH-1:0];
            y_step   = {y_q[WIDTH-2:0], div_ge};
            ovf_step = 1'b0;
         end
         OP_POW: begin
            if (!skip_q) begin
               x_step   = pow_prod[WIDTH-1:0];
               ovf_step = ovf_q | (|pow_prod[2*WIDTH-1:WIDTH]);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      op_d   = op_q;
      x_d    = x_q;
      y_d    = y_q;
      z_d    = z_q;
      ovf_d  = ovf_q;
      skip_d = skip_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (start_i) begin
         op_d   = op_i;
         busy_d = 1'b1;
         ovf_d  = 1'b0;
         skip_d = (b_i == '0);
         case (op_i)
            OP_MUL: begin
               x_d   = '0;
               y_d   = b_i;
               z_d   = a_i;
               cnt_d = IT_W'(WIDTH);
            end
            OP_DIV: begin
               x_d   = '0;
               y_d   = a_i;
               z_d   = b_i;
               cnt_d = IT_W'(WIDTH);
            end
            default: begin
               x_d   = WIDTH'(1);
               y_d   = '0;
               z_d   = a_i;
               cnt_d = (b_i == '0) ? IT_W'(1) : IT_W'(b_i);
            end
         endcase
      end else if (busy_q) begin
         x_d   = x_step;
         y_d   = y_step;
         ovf_d = ovf_step;
         cnt_d = cnt_q - IT_W'(1);
         if (cnt_q == IT_W'(1)) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_NOP;
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
         ovf_q  <= 1'b0;
         skip_q <= 1'b0;
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         op_q   <= op_d;
         x_q    <= x_d;
         y_q    <= y_d;
         z_q    <= z_d;
         ovf_q  <= ovf_d;
         skip_q <= skip_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // done marks the cycle whose step is the last one; res_o/ovf_o carry that step's outcome.
   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == IT_W'(1));
   assign res_o  = (op_q == OP_POW) ? x_step : y_step;
   assign ovf_o  = ovf_step;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU top: handshake FSM, single-cycle ops and flags
// SEQ_ALU_SATURATE_EN defined: ADD/MUL/POW overflow clamps to all ones, SUB borrow clamps to 0.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic [2:0]       oper,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             err
);

`ifdef SEQ_ALU_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [WIDTH-1:0] ONES = '1;

   state_t state_q, state_d;

   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;

   logic             accept;
   logic             div_zero;
   logic             iter_go;
   logic             big_shift;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH-1:0] op_res;
   logic             op_carry;
   logic             op_err;

   logic             iter_busy;
   logic             iter_done;
   logic [WIDTH-1:0] iter_res;
   logic             iter_ovf;
   logic [WIDTH-1:0] iter_final;

   assign accept    = in_valid && in_ready;
   assign div_zero  = (num2 == '0);
   assign iter_go   = accept && is_iter_op(oper, div_zero);
   assign big_shift = (num2 >= WIDTH'(WIDTH));

   seq_alu_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk     (clk),
      .rst     (rst),
      .start_i (iter_go),
      .op_i    (oper),
      .a_i     (num1),
      .b_i     (num2),
      .busy_o  (iter_busy),
      .done_o  (iter_done),
      .res_o   (iter_res),
      .ovf_o   (iter_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = iter_go ? S_EXEC : S_DONE;
         S_EXEC:  if (iter_done) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE:  in_ready = !rst && !iter_busy;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Single-cycle operations are resolved straight from the accepted operands.
   always_comb begin
      add_sum  = {1'b0, num1} + {1'b0, num2};
      sub_diff = {1'b0, num1} - {1'b0, num2};
      op_res   = '0;
      op_carry = 1'b0;
      op_err   = 1'b0;
      case (oper)
         OP_ADD: begin
            op_res   = add_sum[WIDTH-1:0];
            op_carry = add_sum[WIDTH];
            if (SAT_EN && op_carry) op_res = ONES;
         end
         OP_SUB: begin
            op_res   = sub_diff[WIDTH-1:0];
            op_carry = sub_diff[WIDTH];
            if (SAT_EN && op_carry) op_res = '0;
         end
         OP_SHR:  op_res = big_shift ? '0 : (num1 >> num2);
         OP_SHL:  op_res = big_shift ? '0 : (num1 << num2);
         OP_DIV: begin
            op_res = ONES;
            op_err = 1'b1;
         end
         default: op_err = 1'b1;
      endcase
   end

   assign iter_final = (SAT_EN && iter_ovf) ? ONES : iter_res;

   always_comb begin
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      err_d    = err_q;
      if ((state_q == S_IDLE) && accept && !iter_go) begin
         result_d = op_res;
         carry_d  = op_carry;
         zero_d   = (op_res == '0);
         err_d    = op_err;
      end else if ((state_q == S_EXEC) && iter_done) begin
         result_d = iter_final;
         carry_d  = iter_ovf;
         zero_d   = (iter_final == '0);
         err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

   assign result = result_q;
   assign carry  = carry_q;
   assign zero   = zero_q;
   assign err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu against an arithmetic reference model
module tb_seq_alu;

   localparam int W = 8;
   localparam int M = 1 << W;

`ifdef SEQ_ALU_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] num1 = '0;
   logic [W-1:0] num2 = '0;
   logic [2:0]   oper = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         carry;
   logic         zero;
   logic         err;

   int errors = 0;
   int checks = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num1      (num1),
      .num2      (num2),
      .oper      (oper),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int res;
      bit c;
      bit z;
      bit e;
      int lat;
   } exp_t;

   // Reference: plain integer arithmetic; latency counted in edges from accept to out_valid being sampled.
   function automatic exp_t model(input int a, input int b, input int op);
      exp_t   x;
      longint t;
      longint p;
      int     r;
      bit     over;
      x.res = 0; x.c = 1'b0; x.e = 1'b0; x.lat = 1;
      over = 1'b0;
      case (op)
         1: begin
            x.res = (a + b) % M;
            x.c   = (a + b) >= M;
            if (SAT && x.c) x.res = M - 1;
         end
         2: begin
            x.c   = a < b;
            x.res = (a - b + M) % M;
            if (SAT && x.c) x.res = 0;
         end
         3: begin
            p     = longint'(a) * longint'(b);
            x.c   = p >= M;
            x.res = int'(p % M);
            if (SAT && x.c) x.res = M - 1;
            x.lat = W + 1;
         end
         4: begin
            if (b == 0) begin
               x.res = M - 1;
               x.e   = 1'b1;
            end else begin
               x.res = a / b;
               x.lat = W + 1;
            end
         end
         5: x.res = (b >= W) ? 0 : (a >> b);
         6: x.res = (b >= W) ? 0 : ((a << b) % M);
         7: begin
            r = 1;
            t = 1;
            for (int i = 0; i < b; i++) begin
               r = (r * a) % M;
               t = t * a;
               if (t >= M) begin
                  over = 1'b1;
                  t    = M;
               end
            end
            x.res = r;
            x.c   = over;
            if (SAT && x.c) x.res = M - 1;
            x.lat = ((b == 0) ? 1 : b) + 1;
         end
         default: x.e = 1'b1;
      endcase
      x.z = (x.res == 0);
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: tracks the in-flight operation and checks every output on every falling edge.
   bit   pend = 1'b0;
   bit   rst_prev = 1'b0;
   exp_t pexp;
   int   due = 0;
   int   cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst_prev) begin
         pend = 1'b0;
         chk("rst_out_valid", 32'(out_valid), 32'(0));
         chk("rst_result", 32'(result), 32'(0));
         chk("rst_flags", {29'd0, carry, zero, err}, 32'(0));
      end
      chk("in_ready", 32'(in_ready), 32'(!rst && !pend));
      if (pend) begin
         chk("out_valid_timing", 32'(out_valid), 32'(cyc >= due));
         if (out_valid && cyc >= due) begin
            chk("result", 32'(result), 32'(pexp.res));
            chk("carry", 32'(carry), 32'(pexp.c));
            chk("zero", 32'(zero), 32'(pexp.z));
            chk("err", 32'(err), 32'(pexp.e));
            if (out_ready) pend = 1'b0;
         end
      end else begin
         chk("out_valid_idle", 32'(out_valid), 32'(0));
      end
      if (in_valid && in_ready) begin
         pexp = model(int'(num1), int'(num2), int'(oper));
         pend = 1'b1;
         due  = cyc + pexp.lat;
      end
      rst_prev = rst;
   end

   // Present an operation and hold it until the accepting edge has passed.
   task automatic issue(input int a, input int b, input int op, output bit ok);
      int n;
      @(posedge clk); #1;
      num1 = W'(a); num2 = W'(b); oper = 3'(op); in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      ok = in_ready;
      chk("accept_seen", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      num1 = W'($urandom); num2 = W'($urandom); oper = 3'($urandom);
   endtask

   task automatic run_op(input int a, input int b, input int op, input int hold, input bit lit,
                         input int e_res, input int e_c, input int e_z, input int e_e, input int e_lat);
      bit ok;
      int k;
      issue(a, b, op, ok);
      if (!ok) return;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 400);
      chk("out_valid_seen", 32'(out_valid), 32'(1));
      if (lit) begin
         chk("lit_latency", 32'(k), 32'(e_lat));
         chk("lit_result", 32'(result), 32'(e_res));
         chk("lit_carry", 32'(carry), 32'(e_c));
         chk("lit_zero", 32'(zero), 32'(e_z));
         chk("lit_err", 32'(err), 32'(e_e));
      end
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      exp_t m;
      bit   ok;
      int   a, b, op;

      m = model(200, 100, 1);
      chk("pin_add", 32'(m.res), SAT ? 32'(255) : 32'(44));
      m = model(15, 17, 3);
      chk("pin_mul", 32'(m.res), 32'(255));
      m = model(3, 6, 7);
      chk("pin_pow_c", 32'(m.c), 32'(1));
      m = model(100, 7, 4);
      chk("pin_div_lat", 32'(m.lat), 32'(9));

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      run_op(200, 100, 1, 0, 1'b1, SAT ? 255 : 44, 1, 0, 0, 1);
      run_op(5, 7, 2, 0, 1'b1, SAT ? 0 : 254, 1, SAT ? 1 : 0, 0, 1);
      run_op(15, 17, 3, 0, 1'b1, 255, 0, 0, 0, 9);
      run_op(16, 16, 3, 0, 1'b1, SAT ? 255 : 0, 1, SAT ? 0 : 1, 0, 9);
      run_op(100, 7, 4, 0, 1'b1, 14, 0, 0, 0, 9);
      run_op(9, 0, 4, 0, 1'b1, 255, 0, 0, 1, 1);
      run_op(42, 3, 0, 0, 1'b1, 0, 0, 1, 1, 1);
      run_op(2, 3, 7, 0, 1'b1, 8, 0, 0, 0, 4);
      run_op(3, 6, 7, 0, 1'b1, SAT ? 255 : 217, 1, 0, 0, 7);
      run_op(5, 0, 7, 0, 1'b1, 1, 0, 0, 0, 2);
      run_op(1, 9, 6, 0, 1'b1, 0, 0, 1, 0, 1);
      run_op(128, 7, 5, 0, 1'b1, 1, 0, 0, 0, 1);
      run_op(1, 1, 1, 5, 1'b1, 2, 0, 0, 0, 1);

      issue(15, 17, 3, ok);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_op(3, 4, 1, 0, 1'b1, 7, 0, 0, 0, 1);

      for (int i = 0; i < 80; i++) begin
         op = int'($urandom_range(0, 7));
         a  = int'($urandom_range(0, M - 1));
         b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, M - 1));
         if (op == 7 && $urandom_range(0, 1) == 1) b = int'($urandom_range(0, 12));
         run_op(a, b, op, int'($urandom_range(0, 3)), 1'b0, 0, 0, 0, 0, 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
